// File: rtl/router_pkg.sv
// Shared definitions for the router ingress path: direction indices and receiver states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

  localparam int DIRECTIONS   = 5;
  localparam int DIR_N        = 0;
  localparam int DIR_S        = 1;
  localparam int DIR_E        = 2;
  localparam int DIR_W        = 3;
  localparam int DIR_L        = 4;
  localparam int DEFAULT_SIZE = 8;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ingress_arb.sv
// Picks at most one held receiver item per cycle for the shared FIFO.
// Latency: combinational grant; build option RR_ARB_EN adds a last-grant register (round-robin).
// Backpressure: full=1 blocks every grant; losers keep their items in their receivers.
// Ports: valid/items from the five receivers, full from the FIFO side;
//        write/item_out to the FIFO, one-hot item_read back to the winner.
module ingress_arb
  import router_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
`ifdef RR_ARB_EN
  input  logic                             clk,
  input  logic                             reset,
`endif
  input  logic [DIRECTIONS-1:0]            valid,
  input  logic [DIRECTIONS-1:0][SIZE-1:0]  items,
  input  logic                             full,
  output logic                             write,
  output logic [SIZE-1:0]                  item_out,
  output logic [DIRECTIONS-1:0]            item_read
);

  localparam int SW = $clog2(DIRECTIONS);

  logic          found;
  logic [SW-1:0] sel;

`ifdef RR_ARB_EN
  logic [SW-1:0] last_q;
  int            idx;

  // Search starts just after the previous winner so every port gets a turn.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= DIRECTIONS; k++) begin
      idx = (int'(last_q) + k) % DIRECTIONS;
      if (!found && valid[idx]) begin
        found = 1'b1;
        sel   = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last_q <= SW'(DIR_L);
    else if (write) last_q <= sel;
  end
`else
  // Fixed priority: lowest index (north) wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DIR_N; i < DIRECTIONS; i++) begin
      if (!found && valid[i]) begin
        found = 1'b1;
        sel   = SW'(i);
      end
    end
  end
`endif

  always_comb begin
    write     = 1'b0;
    item_out  = '0;
    item_read = '0;
    if (!full && found) begin
      write          = 1'b1;
      item_out       = items[sel];
      item_read[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/item_fifo.sv
// Circular first-word-fall-through FIFO of SIZE-bit items, DEPTH entries (power of two).
// Latency: a written item is visible at item_out the cycle after the write edge.
// Backpressure: full when DEPTH items held; a write is still taken at full if a read frees a slot on the same edge.
// Ports: write/item_in push side; read pop side; item_out head; empty/full from the item count.
module item_fifo #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write,
  input  logic [SIZE-1:0] item_in,
  input  logic            read,
  output logic [SIZE-1:0] item_out,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(DEPTH);

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic            rd_acc, wr_acc;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_acc   = read && !empty;
  // A pop on the same edge frees the slot, so a full FIFO can still take a push.
  assign wr_acc   = write && (!full || rd_acc);
  assign item_out = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= item_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx.sv
// One serial channel receiver: start bit, then SIZE data bits LSB first, then hold until read.
// Latency: item valid the cycle after the last data bit is sampled.
// Backpressure: channel_busy stays high from after the start bit until the cycle after item_read.
// Ports: clk, reset (async, active-high); serial_in line; item_read from arbiter;
//        valid / parallel_out present the held item; channel_busy to the upstream sender.
module serial_rx
  import router_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_in,
  input  logic            item_read,
  output logic            valid,
  output logic            channel_busy,
  output logic [SIZE-1:0] parallel_out
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] shreg_q;
  logic            busy_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: if (serial_in) state_d = RX_RECV;
      RX_RECV: if (cnt_q == CW'(SIZE - 1)) state_d = RX_HOLD;
      RX_HOLD: if (item_read) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == RX_RECV) ? cnt_q + 1'b1 : '0;
      // Data arrives LSB first, so shift in from the top.
      if (state_q == RX_RECV) shreg_q <= {serial_in, shreg_q[SIZE-1:1]};
      // Anything other than IDLE next cycle means the line must stay quiet.
      busy_q  <= (state_d != RX_IDLE);
    end
  end

  assign valid        = (state_q == RX_HOLD);
  assign channel_busy = busy_q;
  assign parallel_out = shreg_q;

endmodule

// File: rtl/router_ingress.sv
// Mesh router receive side: five serial receivers, one arbiter, one shared FWFT item FIFO.
// Latency: last data bit at edge T -> written at T+1 -> visible at fifo_item_out after T+1.
// Backpressure: rx_busy per channel; held items wait while the FIFO is full. Build option RR_ARB_EN selects round-robin.
// Ports: clk, reset (async, active-high); rx_data[4:0] serial lines (N,S,E,W,L); rx_busy[4:0];
//        fifo_item_out / fifo_empty / fifo_full head status; fifo_read pops the head.
module router_ingress
  import router_pkg::*;
#(
  parameter int SIZE     = DEFAULT_SIZE,
  parameter int DEPTH    = 8,
  parameter int ROUTERID = -1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIRECTIONS-1:0] rx_data,
  output logic [DIRECTIONS-1:0] rx_busy,
  output logic [SIZE-1:0]       fifo_item_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  input  logic                  fifo_read
);

  logic [DIRECTIONS-1:0]           rx_valid;
  logic [DIRECTIONS-1:0][SIZE-1:0] rx_items;
  logic [DIRECTIONS-1:0]           item_read;
  logic                            arb_write;
  logic [SIZE-1:0]                 arb_item;
  logic                            arb_full;

  for (genvar g = 0; g < DIRECTIONS; g++) begin : g_rx
    serial_rx #(.SIZE(SIZE)) u_rx (
      .clk          (clk),
      .reset        (reset),
      .serial_in    (rx_data[g]),
      .item_read    (item_read[g]),
      .valid        (rx_valid[g]),
      .channel_busy (rx_busy[g]),
      .parallel_out (rx_items[g])
    );
  end

  // A full FIFO being popped this edge has room, so a held item moves in without a bubble.
  assign arb_full = fifo_full && !fifo_read;

  ingress_arb #(.SIZE(SIZE)) u_arb (
`ifdef RR_ARB_EN
    .clk       (clk),
    .reset     (reset),
`endif
    .valid     (rx_valid),
    .items     (rx_items),
    .full      (arb_full),
    .write     (arb_write),
    .item_out  (arb_item),
    .item_read (item_read)
  );

  item_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .write    (arb_write),
    .item_in  (arb_item),
    .read     (fifo_read),
    .item_out (fifo_item_out),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  a_one_grant: assert property (@(posedge clk) disable iff (reset) $onehot0(item_read))
    else $error("router_ingress %0d: more than one receiver granted", ROUTERID);

endmodule

// File: tb/tb_router_ingress.sv
// Randomised bench for router_ingress against a queue-based behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_router_ingress;

  localparam int SIZE  = 8;
  localparam int DEPTH = 8;
  localparam int NP    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   rx_data;
  logic [NP-1:0]   rx_busy;
  logic [SIZE-1:0] fifo_item_out;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_read;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per-channel frame progress and held item, plus the FIFO as a queue.
  int              m_idx  [NP];
  bit              m_hold [NP];
  logic [SIZE-1:0] m_hdat [NP];
  logic [SIZE-1:0] m_cur  [NP];
  logic [SIZE-1:0] pend   [NP][$];
  logic [SIZE-1:0] q[$];
  int              m_last;
  int              start_pct;
  int              rd_mode;

  router_ingress #(.SIZE(SIZE), .DEPTH(DEPTH), .ROUTERID(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_busy       (rx_busy),
    .fifo_item_out (fifo_item_out),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_read     (fifo_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] model_busy();
    logic [NP-1:0] b;
    for (int p = 0; p < NP; p++) b[p] = (m_idx[p] >= 0) || m_hold[p];
    return b;
  endfunction

  function automatic bit model_quiet();
    bit qt;
    qt = (q.size() == 0);
    for (int p = 0; p < NP; p++)
      if (m_idx[p] >= 0 || m_hold[p] || pend[p].size() > 0) qt = 1'b0;
    return qt;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_idx[p]  = -1;
      m_hold[p] = 1'b0;
      m_hdat[p] = '0;
      m_cur[p]  = '0;
      pend[p].delete();
    end
    q.delete();
    m_last = NP - 1;
  endtask

  task automatic compare();
    chk("rx_busy", 32'(rx_busy), 32'(model_busy()));
    chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
    chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    if (q.size() > 0) chk("fifo_item_out", 32'(fifo_item_out), 32'(q[0]));
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (m_idx[p] >= 0) rx_data[p] = m_cur[p][m_idx[p]];
      else if (m_hold[p]) rx_data[p] = 1'($urandom);  // must be ignored while holding
      else if (pend[p].size() > 0 && $urandom_range(0, 99) < start_pct) begin
        m_cur[p]   = pend[p].pop_front();
        rx_data[p] = 1'b1;
      end else rx_data[p] = 1'b0;
    end
    case (rd_mode)
      1:       fifo_read = 1'b1;
      2:       fifo_read = 1'($urandom);
      3:       fifo_read = ($urandom_range(0, 3) == 0);
      default: fifo_read = 1'b0;
    endcase
  endtask

  // Advance the model across one rising edge using the inputs just driven.
  task automatic model_edge();
    int g;
    bit rd;
    g  = -1;
    rd = fifo_read && (q.size() > 0);
    if (q.size() < DEPTH || rd) begin
`ifdef RR_ARB_EN
      for (int k = 1; k <= NP; k++)
        if (g < 0 && m_hold[(m_last + k) % NP]) g = (m_last + k) % NP;
`else
      for (int p = 0; p < NP; p++)
        if (g < 0 && m_hold[p]) g = p;
`endif
    end
    if (rd) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back(m_hdat[g]);
      m_last = g;
    end
    for (int p = 0; p < NP; p++) begin
      if (m_hold[p]) begin
        if (p == g) m_hold[p] = 1'b0;
      end else if (m_idx[p] >= 0) begin
        if (m_idx[p] == SIZE - 1) begin
          m_hold[p] = 1'b1;
          m_hdat[p] = m_cur[p];
          m_idx[p]  = -1;
        end else m_idx[p]++;
      end else if (rx_data[p]) m_idx[p] = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    drive();
    model_edge();
    @(posedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_quiet(input string tag, input int budget);
    int i;
    i = 0;
    while (!model_quiet() && i < budget) begin
      cycle();
      i++;
    end
    @(negedge clk);
    chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    chk({tag, "_idle"}, 32'(rx_busy), 32'd0);
    rx_data   = '0;
    fifo_read = 1'b0;
  endtask

  initial begin
    logic [SIZE-1:0] exp_ord [3];
    exp_ord = '{8'h11, 8'h22, 8'h33};
    reset     = 1'b1;
    rx_data   = '0;
    fifo_read = 1'b0;
    start_pct = 100;
    rd_mode   = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    chk("reset_empty", 32'(fifo_empty), 32'd1);
    chk("reset_full", 32'(fifo_full), 32'd0);
    chk("reset_item", 32'(fifo_item_out), 32'd0);
    reset = 1'b0;

    // Three channels finish together; arbitration order N, E, L.
    pend[0].push_back(8'h11);
    pend[2].push_back(8'h22);
    pend[4].push_back(8'h33);
    run(12);
    rd_mode = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("same_cycle_order", 32'(fifo_item_out), 32'(exp_ord[i]));
      cycle();
    end
    run_quiet("order", 50);

    // Single north frame 0xA5.
    rd_mode = 0;
    pend[0].push_back(8'hA5);
    run(10);
    #1 chk("a5_item", 32'(fifo_item_out), 32'hA5);
    chk("a5_empty", 32'(fifo_empty), 32'd0);
    rd_mode = 1;
    run_quiet("a5", 50);

    // Reads while empty, then a read and write on the same edge when empty.
    run(3);
    pend[1].push_back(8'h3C);
    run(10);
    #1 chk("rw_empty_item", 32'(fifo_item_out), 32'h3C);
    chk("rw_empty_notempty", 32'(fifo_empty), 32'd0);
    run_quiet("rw_empty", 50);

    // Fill to DEPTH with one frame left holding.
    rd_mode = 0;
    for (int p = 0; p < 4; p++) begin
      pend[p].push_back(SIZE'(8'h40 + p));
      pend[p].push_back(SIZE'(8'h50 + p));
    end
    pend[4].push_back(8'h64);
    run(40);
    #1 chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_one_held", 32'($countones(rx_busy)), 32'd1);
    rd_mode = 1;
    run(1);
    rd_mode = 0;
    #1 chk("pop_full_stays", 32'(fifo_full), 32'd1);
    chk("pop_held_taken", 32'($countones(rx_busy)), 32'd0);
    rd_mode = 1;
    run_quiet("fill", 100);

    // Stream items 0..20 with random reads and starts.
    start_pct = 50;
    rd_mode   = 2;
    for (int i = 0; i <= 20; i++) pend[$urandom_range(0, NP - 1)].push_back(SIZE'(i));
    run_quiet("stream", 2000);

    // Random traffic with slow draining to exercise full/backpressure.
    start_pct = 40;
    rd_mode   = 3;
    for (int i = 0; i < 150; i++) pend[$urandom_range(0, NP - 1)].push_back(SIZE'($urandom));
    rd_mode = 3;
    run(600);
    rd_mode = 2;
    run_quiet("random", 8000);

    // Reset in the middle of a west frame with an item sitting in the FIFO.
    start_pct = 100;
    rd_mode   = 0;
    pend[0].push_back(8'hC3);
    run(12);
    pend[3].push_back(8'h77);
    run(5);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("midreset_busy", 32'(rx_busy), 32'd0);
    chk("midreset_empty", 32'(fifo_empty), 32'd1);
    chk("midreset_item", 32'(fifo_item_out), 32'd0);
    model_reset();
    rx_data   = '0;
    fifo_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pend[3].push_back(8'h5A);
    run(11);
    #1 chk("after_reset_item", 32'(fifo_item_out), 32'h5A);
    rd_mode = 1;
    run_quiet("after_reset", 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
